// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: initiator port state encoding
// and the encodings of the bus_mode and bus_m_rw signals.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        WDATA,
        WAIT_ACK,
        RDATA
    } m_state_t;

    localparam logic BUS_MODE_ADDR = 1'b0;
    localparam logic BUS_MODE_DATA = 1'b1;
    localparam logic BUS_RW_WRITE  = 1'b1;
    localparam logic BUS_RW_READ   = 1'b0;

endpackage

// File: rtl/m_port.sv
// Initiator-side serial bus port: takes one parallel request, wins the bus, shifts the
// address and write data out LSB first, and collects the ack or the serial read data.
module m_port
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m_valid,
    input  logic                  m_rw,
    input  logic [ADDR_WIDTH-1:0] m_addr,
    input  logic [DATA_WIDTH-1:0] m_wdata,
    output logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  m_rdata_valid,
    output logic                  m_done,
    output logic                  m_err,
    output logic                  bus_m_req,
    input  logic                  bus_m_grant,
    output logic                  bus_data_out,
    output logic                  bus_data_out_valid,
    output logic                  bus_mode,
    output logic                  bus_m_rw,
    input  logic                  bus_data_in,
    input  logic                  bus_data_in_valid,
    input  logic                  bus_s_ack
);

    localparam int unsigned MaxW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int unsigned CntW  = $clog2(MaxW + 1);
    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
    localparam int unsigned RIdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CntW-1:0]  AddrLast = CntW'(ADDR_WIDTH - 1);
    localparam logic [CntW-1:0]  DataLast = CntW'(DATA_WIDTH - 1);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);

    m_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;
    logic [DATA_WIDTH-1:0] data_sh_q, data_sh_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdleW-1:0]      idle_q, idle_d;

    logic                  m_ready_q, m_ready_d;
    logic [DATA_WIDTH-1:0] m_rdata_q, m_rdata_d;
    logic                  m_rdata_valid_q, m_rdata_valid_d;
    logic                  m_done_q, m_done_d;
    logic                  m_err_q, m_err_d;
    logic                  bus_m_req_q, bus_m_req_d;
    logic                  bus_data_out_q, bus_data_out_d;
    logic                  bus_data_out_valid_q, bus_data_out_valid_d;
    logic                  bus_mode_q, bus_mode_d;
    logic                  bus_m_rw_q, bus_m_rw_d;

    logic                  txn_end;
    logic                  txn_err;
    logic [RIdxW-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] cap_next;

    always_comb begin
        rd_idx           = cnt_q[RIdxW-1:0];
        cap_next         = cap_q;
        cap_next[rd_idx] = bus_data_in;
    end

    always_comb begin
        state_d              = state_q;
        addr_sh_d            = addr_sh_q;
        data_sh_d            = data_sh_q;
        cap_d                = cap_q;
        cnt_d                = cnt_q;
        idle_d               = idle_q;
        m_ready_d            = m_ready_q;
        m_rdata_d            = m_rdata_q;
        m_rdata_valid_d      = 1'b0;
        m_done_d             = 1'b0;
        m_err_d              = 1'b0;
        bus_m_req_d          = bus_m_req_q;
        bus_data_out_d       = bus_data_out_q;
        bus_data_out_valid_d = bus_data_out_valid_q;
        bus_mode_d           = bus_mode_q;
        bus_m_rw_d           = bus_m_rw_q;
        txn_end              = 1'b0;
        txn_err              = 1'b0;

        unique case (state_q)
            IDLE: begin
                // m_ready_q is low in the m_done cycle, which enforces one idle cycle
                m_ready_d = 1'b1;
                if (m_ready_q && m_valid) begin
                    addr_sh_d   = m_addr;
                    data_sh_d   = m_wdata;
                    bus_m_rw_d  = m_rw;
                    m_ready_d   = 1'b0;
                    bus_m_req_d = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (bus_m_grant) begin
                    state_d              = ADDR;
                    cnt_d                = '0;
                    bus_mode_d           = BUS_MODE_ADDR;
                    bus_data_out_valid_d = 1'b1;
                    bus_data_out_d       = addr_sh_q[0];
                    addr_sh_d            = addr_sh_q >> 1;
                end
            end
            ADDR: begin
                if (!bus_m_grant) begin
                    txn_end = 1'b1;
                    txn_err = 1'b1;
                end else if (cnt_q == AddrLast) begin
                    cnt_d      = '0;
                    idle_d     = '0;
                    bus_mode_d = BUS_MODE_DATA;
                    if (bus_m_rw_q == BUS_RW_WRITE) begin
                        state_d        = WDATA;
                        bus_data_out_d = data_sh_q[0];
                        data_sh_d      = data_sh_q >> 1;
                    end else begin
                        state_d              = RDATA;
                        cap_d                = '0;
                        bus_data_out_valid_d = 1'b0;
                        bus_data_out_d       = 1'b0;
                    end
                end else begin
                    cnt_d          = cnt_q + 1'b1;
                    bus_data_out_d = addr_sh_q[0];
                    addr_sh_d      = addr_sh_q >> 1;
                end
            end
            WDATA: begin
                if (!bus_m_grant) begin
                    txn_end = 1'b1;
                    txn_err = 1'b1;
                end else if (cnt_q == DataLast) begin
                    state_d              = WAIT_ACK;
                    idle_d               = '0;
                    bus_data_out_valid_d = 1'b0;
                    bus_data_out_d       = 1'b0;
                end else begin
                    cnt_d          = cnt_q + 1'b1;
                    bus_data_out_d = data_sh_q[0];
                    data_sh_d      = data_sh_q >> 1;
                end
            end
            WAIT_ACK: begin
                // Ack beats both grant loss and timeout expiry in the same cycle
                if (bus_s_ack) begin
                    txn_end = 1'b1;
                end else if (!bus_m_grant || idle_q == IdleLast) begin
                    txn_end = 1'b1;
                    txn_err = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            RDATA: begin
                if (bus_data_in_valid && cnt_q == DataLast) begin
                    txn_end         = 1'b1;
                    m_rdata_d       = cap_next;
                    m_rdata_valid_d = 1'b1;
                end else if (!bus_m_grant) begin
                    txn_end = 1'b1;
                    txn_err = 1'b1;
                end else if (bus_data_in_valid) begin
                    cap_d  = cap_next;
                    cnt_d  = cnt_q + 1'b1;
                    idle_d = '0;
                end else if (idle_q == IdleLast) begin
                    txn_end = 1'b1;
                    txn_err = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (txn_end) begin
            state_d              = IDLE;
            m_done_d             = 1'b1;
            m_err_d              = txn_err;
            bus_m_req_d          = 1'b0;
            bus_data_out_valid_d = 1'b0;
            bus_data_out_d       = 1'b0;
            bus_mode_d           = BUS_MODE_ADDR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q              <= IDLE;
            addr_sh_q            <= '0;
            data_sh_q            <= '0;
            cap_q                <= '0;
            cnt_q                <= '0;
            idle_q               <= '0;
            m_ready_q            <= 1'b1;
            m_rdata_q            <= '0;
            m_rdata_valid_q      <= 1'b0;
            m_done_q             <= 1'b0;
            m_err_q              <= 1'b0;
            bus_m_req_q          <= 1'b0;
            bus_data_out_q       <= 1'b0;
            bus_data_out_valid_q <= 1'b0;
            bus_mode_q           <= BUS_MODE_ADDR;
            bus_m_rw_q           <= BUS_RW_READ;
        end else begin
            state_q              <= state_d;
            addr_sh_q            <= addr_sh_d;
            data_sh_q            <= data_sh_d;
            cap_q                <= cap_d;
            cnt_q                <= cnt_d;
            idle_q               <= idle_d;
            m_ready_q            <= m_ready_d;
            m_rdata_q            <= m_rdata_d;
            m_rdata_valid_q      <= m_rdata_valid_d;
            m_done_q             <= m_done_d;
            m_err_q              <= m_err_d;
            bus_m_req_q          <= bus_m_req_d;
            bus_data_out_q       <= bus_data_out_d;
            bus_data_out_valid_q <= bus_data_out_valid_d;
            bus_mode_q           <= bus_mode_d;
            bus_m_rw_q           <= bus_m_rw_d;
        end
    end

    assign m_ready            = m_ready_q;
    assign m_rdata            = m_rdata_q;
    assign m_rdata_valid      = m_rdata_valid_q;
    assign m_done             = m_done_q;
    assign m_err              = m_err_q;
    assign bus_m_req          = bus_m_req_q;
    assign bus_data_out       = bus_data_out_q;
    assign bus_data_out_valid = bus_data_out_valid_q;
    assign bus_mode           = bus_mode_q;
    assign bus_m_rw           = bus_m_rw_q;

endmodule

// File: tb/tb_m_port.sv
// Self-checking bench for m_port: an in-bench arbiter/target drives the bus side and
// each transaction's observed serial stream and completion are checked against its request.
module tb_m_port;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_valid = 1'b0;
    logic        m_rw = 1'b0;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wdata = '0;
    logic        m_ready;
    logic [7:0]  m_rdata;
    logic        m_rdata_valid;
    logic        m_done;
    logic        m_err;
    logic        bus_m_req;
    logic        bus_m_grant = 1'b0;
    logic        bus_data_out;
    logic        bus_data_out_valid;
    logic        bus_mode;
    logic        bus_m_rw;
    logic        bus_data_in = 1'b0;
    logic        bus_data_in_valid = 1'b0;
    logic        bus_s_ack = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_rdata = '0;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  wd;
        logic [7:0]  rd;
        int          nbits;
        int          mode_bad;
        int          rw_bad;
        int          req_bad;
        int          t_wait;
        bit          done;
        bit          err;
        bit          rv;
        bit          req_acc;
        bit          req_done;
        bit          ready_done;
        bit          valid_done;
        bit          ready_next;
        bit          done_next;
    } obs_t;

    m_port #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .m_valid           (m_valid),
        .m_rw              (m_rw),
        .m_addr            (m_addr),
        .m_wdata           (m_wdata),
        .m_ready           (m_ready),
        .m_rdata           (m_rdata),
        .m_rdata_valid     (m_rdata_valid),
        .m_done            (m_done),
        .m_err             (m_err),
        .bus_m_req         (bus_m_req),
        .bus_m_grant       (bus_m_grant),
        .bus_data_out      (bus_data_out),
        .bus_data_out_valid(bus_data_out_valid),
        .bus_mode          (bus_mode),
        .bus_m_rw          (bus_m_rw),
        .bus_data_in       (bus_data_in),
        .bus_data_in_valid (bus_data_in_valid),
        .bus_s_ack         (bus_s_ack)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    // Arbiter + target model: runs one request and records what the port did on the bus.
    task automatic do_txn(input bit rw, input logic [15:0] addr, input logic [7:0] wd,
                          input logic [7:0] rdat, input int gap, input int gdelay,
                          input int drop_addr, input bit drop_r8, input bit no_ack,
                          output obs_t o);
        int k;
        int j;
        int gc;
        int t_entry;
        int cyc;
        o = '{default: 0};
        o.t_wait = -1;
        k = 0;
        j = 0;
        gc = 0;
        t_entry = -1;
        cyc = 0;
        while (!m_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        m_valid = 1'b1;
        m_rw    = rw;
        m_addr  = addr;
        m_wdata = wd;
        tick();
        m_valid   = 1'b0;
        m_rw      = 1'($urandom);
        m_addr    = 16'($urandom);
        m_wdata   = 8'($urandom);
        o.req_acc = bus_m_req;
        repeat (gdelay) tick();
        bus_m_grant = 1'b1;
        for (cyc = 0; cyc < 400; cyc++) begin
            tick();
            bus_s_ack         = 1'b0;
            bus_data_in_valid = 1'b0;
            // Stray read bits outside the read phase must be ignored
            if (k < 16) begin
                bus_data_in_valid = 1'($urandom);
                bus_data_in       = 1'($urandom);
            end
            if (m_done) begin
                o.done       = 1'b1;
                o.err        = m_err;
                o.rv         = m_rdata_valid;
                o.rd         = m_rdata;
                o.req_done   = bus_m_req;
                o.ready_done = m_ready;
                o.valid_done = bus_data_out_valid;
                if (t_entry >= 0) o.t_wait = cyc - t_entry;
                break;
            end
            if (bus_m_rw !== rw) o.rw_bad++;
            if (bus_m_req !== 1'b1) o.req_bad++;
            if (bus_data_out_valid) begin
                if (k < 16) begin
                    o.a[k] = bus_data_out;
                    if (bus_mode !== 1'b0) o.mode_bad++;
                end else begin
                    if (k < 24) o.wd[k-16] = bus_data_out;
                    if (bus_mode !== 1'b1) o.mode_bad++;
                end
                if (k == drop_addr) bus_m_grant = 1'b0;
                k++;
            end else if (k >= 16) begin
                if (bus_mode !== 1'b1) o.mode_bad++;
                if (t_entry < 0) t_entry = cyc;
                if (rw && !no_ack && (cyc - t_entry) >= gap) bus_s_ack = 1'b1;
                if (!rw) begin
                    if (gc == 0 && j < 8) begin
                        bus_data_in_valid = 1'b1;
                        bus_data_in       = rdat[j];
                        if (j == 7 && drop_r8) bus_m_grant = 1'b0;
                        j++;
                        gc = gap;
                    end else if (gc > 0) begin
                        gc--;
                    end
                end
            end
        end
        o.nbits = k;
        if (o.done) begin
            tick();
            o.done_next  = m_done;
            o.ready_next = m_ready;
        end
        bus_m_grant       = 1'b0;
        bus_s_ack         = 1'b0;
        bus_data_in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({m_ready, m_rdata_valid, m_done, m_err, bus_m_req, bus_data_out,
             bus_data_out_valid, bus_mode, bus_m_rw} !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b exp %b", {m_ready, m_rdata_valid, m_done, m_err,
                     bus_m_req, bus_data_out, bus_data_out_valid, bus_mode, bus_m_rw},
                     9'b1_0000_0000);
        end
        checks++;
        if (m_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata: got %h exp 00", m_rdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_directed;
        obs_t o;
        do_txn(1'b1, 16'h1234, 8'hA5, 8'h00, 0, 3, -1, 1'b0, 1'b0, o);
        checks++;
        if (o.req_acc !== 1'b1) begin errors++; $display("FAIL wr_req_rise: got %b exp 1", o.req_acc); end
        checks++;
        if (o.a !== 16'h1234) begin errors++; $display("FAIL wr_addr_bits: got %h exp 1234", o.a); end
        checks++;
        if (o.wd !== 8'hA5) begin errors++; $display("FAIL wr_data_bits: got %h exp a5", o.wd); end
        checks++;
        if (o.nbits != 24) begin errors++; $display("FAIL wr_nbits: got %0d exp 24", o.nbits); end
        checks++;
        if (o.mode_bad + o.rw_bad + o.req_bad != 0) begin
            errors++;
            $display("FAIL wr_bus_ctrl: got mode/rw/req bad %0d/%0d/%0d exp 0/0/0",
                     o.mode_bad, o.rw_bad, o.req_bad);
        end
        checks++;
        if ({o.done, o.err, o.rv} !== 3'b100) begin
            errors++;
            $display("FAIL wr_done: got done/err/rv %b exp 100", {o.done, o.err, o.rv});
        end
        checks++;
        if ({o.req_done, o.ready_done, o.ready_next, o.done_next} !== 4'b0010) begin
            errors++;
            $display("FAIL wr_turnaround: got %b exp 0010",
                     {o.req_done, o.ready_done, o.ready_next, o.done_next});
        end
        checks++;
        if (m_rdata !== exp_rdata) begin errors++; $display("FAIL wr_rdata_hold: got %h exp %h", m_rdata, exp_rdata); end
    endtask

    task automatic test_read_directed;
        obs_t o;
        do_txn(1'b0, 16'h00FF, 8'($urandom), 8'h3C, 2, 1, -1, 1'b0, 1'b0, o);
        exp_rdata = 8'h3C;
        checks++;
        if (o.a !== 16'h00FF || o.nbits != 16) begin
            errors++;
            $display("FAIL rd_addr: got %h/%0d exp 00ff/16", o.a, o.nbits);
        end
        checks++;
        if (o.mode_bad + o.rw_bad + o.req_bad != 0) begin
            errors++;
            $display("FAIL rd_bus_ctrl: got mode/rw/req bad %0d/%0d/%0d exp 0/0/0",
                     o.mode_bad, o.rw_bad, o.req_bad);
        end
        checks++;
        if ({o.done, o.err, o.rv, o.done_next} !== 4'b1010) begin
            errors++;
            $display("FAIL rd_pulse: got done/err/rv/next %b exp 1010",
                     {o.done, o.err, o.rv, o.done_next});
        end
        checks++;
        if (o.rd !== exp_rdata) begin errors++; $display("FAIL rd_data: got %h exp %h", o.rd, exp_rdata); end
    endtask

    task automatic test_timeout;
        obs_t o;
        do_txn(1'b1, 16'($urandom), 8'($urandom), 8'h00, 0, 0, -1, 1'b0, 1'b1, o);
        checks++;
        if ({o.done, o.err} !== 2'b11) begin
            errors++;
            $display("FAIL to_err: got done/err %b exp 11", {o.done, o.err});
        end
        checks++;
        if (o.t_wait != TIMEOUT) begin
            errors++;
            $display("FAIL to_latency: got %0d exp %0d", o.t_wait, TIMEOUT);
        end
        checks++;
        if ({o.req_done, o.ready_next} !== 2'b01) begin
            errors++;
            $display("FAIL to_release: got req/ready_next %b exp 01", {o.req_done, o.ready_next});
        end
        checks++;
        if (m_rdata !== exp_rdata) begin errors++; $display("FAIL to_rdata: got %h exp %h", m_rdata, exp_rdata); end
    endtask

    task automatic test_grant_loss;
        obs_t o;
        do_txn(1'b0, 16'($urandom), 8'($urandom), 8'($urandom), 0, 2, 7, 1'b0, 1'b0, o);
        checks++;
        if (o.nbits != 8) begin errors++; $display("FAIL gl_nbits: got %0d exp 8", o.nbits); end
        checks++;
        if ({o.done, o.err, o.rv, o.valid_done} !== 4'b1100) begin
            errors++;
            $display("FAIL gl_abort: got done/err/rv/valid %b exp 1100",
                     {o.done, o.err, o.rv, o.valid_done});
        end
        checks++;
        if (o.rd !== exp_rdata) begin errors++; $display("FAIL gl_rdata: got %h exp %h", o.rd, exp_rdata); end
    endtask

    task automatic test_read_coincide;
        obs_t o;
        logic [7:0] d;
        d = 8'($urandom);
        do_txn(1'b0, 16'($urandom), 8'($urandom), d, 0, 0, -1, 1'b1, 1'b0, o);
        exp_rdata = d;
        checks++;
        if ({o.done, o.err, o.rv} !== 3'b101) begin
            errors++;
            $display("FAIL co_win: got done/err/rv %b exp 101", {o.done, o.err, o.rv});
        end
        checks++;
        if (o.rd !== exp_rdata) begin errors++; $display("FAIL co_rdata: got %h exp %h", o.rd, exp_rdata); end
    endtask

    task automatic test_reset_mid_wdata;
        obs_t o;
        int k;
        bit seen_done;
        logic [15:0] a;
        logic [7:0] d;
        k = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 50 && !m_ready; i++) tick();
        m_valid = 1'b1;
        m_rw    = 1'b1;
        m_addr  = 16'($urandom);
        m_wdata = 8'($urandom);
        tick();
        m_valid = 1'b0;
        bus_m_grant = 1'b1;
        for (int i = 0; i < 100 && k < 20; i++) begin
            tick();
            if (bus_data_out_valid) k++;
        end
        checks++;
        if (bus_mode !== 1'b1 || bus_data_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: got mode/valid %b%b exp 11", bus_mode, bus_data_out_valid);
        end
        #2 rst = 1'b1;
        #1;
        exp_rdata = 8'h00;
        checks++;
        if ({m_ready, m_rdata_valid, m_done, m_err, bus_m_req, bus_data_out,
             bus_data_out_valid, bus_mode, bus_m_rw} !== 9'b1_0000_0000 || m_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL rst_async: got %b/%h exp 100000000/00", {m_ready, m_rdata_valid, m_done,
                     m_err, bus_m_req, bus_data_out, bus_data_out_valid, bus_mode, bus_m_rw}, m_rdata);
        end
        bus_m_grant = 1'b0;
        repeat (2) begin
            tick();
            if (m_done) seen_done = 1'b1;
        end
        rst = 1'b0;
        repeat (3) begin
            tick();
            if (m_done) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin errors++; $display("FAIL rst_no_done: got 1 exp 0"); end
        a = 16'($urandom);
        d = 8'($urandom);
        do_txn(1'b1, a, d, 8'h00, 1, 1, -1, 1'b0, 1'b0, o);
        checks++;
        if (o.a !== a || o.wd !== d || {o.done, o.err} !== 2'b10) begin
            errors++;
            $display("FAIL rst_recover: got %h/%h/%b exp %h/%h/10", o.a, o.wd, {o.done, o.err}, a, d);
        end
    endtask

    task automatic test_back_to_back;
        obs_t o;
        bit rw;
        logic [15:0] a;
        logic [7:0] d;
        logic [7:0] r;
        for (int n = 0; n < 16; n++) begin
            rw = 1'($urandom);
            a  = 16'($urandom);
            d  = 8'($urandom);
            r  = 8'($urandom);
            do_txn(rw, a, d, r, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                   -1, 1'b0, 1'b0, o);
            if (!rw) exp_rdata = r;
            checks++;
            if (o.a !== a || o.nbits != (rw ? 24 : 16) || (rw && o.wd !== d)) begin
                errors++;
                $display("FAIL b2b_serial[%0d]: got %h/%h/%0d exp %h/%h/%0d", n, o.a, o.wd,
                         o.nbits, a, d, rw ? 24 : 16);
            end
            checks++;
            if ({o.done, o.err, o.rv, o.ready_next} !== {3'b100 | {2'b00, !rw}, 1'b1} ||
                o.mode_bad + o.rw_bad + o.req_bad != 0) begin
                errors++;
                $display("FAIL b2b_ctrl[%0d]: got %b bad %0d/%0d/%0d exp %b bad 0/0/0", n,
                         {o.done, o.err, o.rv, o.ready_next}, o.mode_bad, o.rw_bad, o.req_bad,
                         {3'b100 | {2'b00, !rw}, 1'b1});
            end
            checks++;
            if (m_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL b2b_rdata[%0d]: got %h exp %h", n, m_rdata, exp_rdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_directed();
        test_read_directed();
        test_timeout();
        test_grant_loss();
        test_read_coincide();
        test_reset_mid_wdata();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_port.md
Name: m_port

Overview:
- Initiator-side serial bus port; sits between a master device and the serial system bus, directly upstream of the target port.
- Accepts one parallel read/write request at a time and requests the bus from the arbiter.
- Serialises the 16-bit address, then the 8-bit write data, LSB first.
- Reports completion: on a write, from the target's ack; on a read, after deserialising the 8 returned data bits.

Parameters:
- ADDR_WIDTH, 16, address bits serialised per transaction.
- DATA_WIDTH, 8, data bits per transfer, both directions.
- TIMEOUT, 64, maximum idle cycles allowed in WAIT_ACK/RDATA before abort; must be ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- m_valid  in  1  master request valid.
- m_rw  in  1  1 = write, 0 = read.
- m_addr  in  ADDR_WIDTH  request address.
- m_wdata  in  DATA_WIDTH  write data.
- m_ready  out  1  port idle; request accepted when m_valid && m_ready.
- m_rdata  out  DATA_WIDTH  read data, held until the next read completes.
- m_rdata_valid  out  1  1-cycle pulse: read data valid.
- m_done  out  1  1-cycle pulse: transaction finished (success or error).
- m_err  out  1  1-cycle pulse coincident with m_done on timeout or grant loss.
- bus_m_req  out  1  bus request to arbiter.
- bus_m_grant  in  1  arbiter grant.
- bus_data_out  out  1  serial data to bus.
- bus_data_out_valid  out  1  serial bit valid.
- bus_mode  out  1  1 = data phase, 0 = address phase.
- bus_m_rw  out  1  latched request direction.
- bus_data_in  in  1  serial read data from target.
- bus_data_in_valid  in  1  read bit valid.
- bus_s_ack  in  1  target write acknowledge.

Behaviour:
- Reset values: all outputs 0 except m_ready = 1. State = IDLE; counters, shift and capture registers = 0.
- Reset is asynchronous mid-transaction and returns to IDLE in all cases. No m_done is issued for the killed transaction.
- All outputs are driven from flops: no combinational path from any input to any output.
- IDLE:
  - m_ready = 1.
  - On m_valid: latch m_addr into the address shift register, m_wdata into the data shift register, and m_rw into bus_m_rw.
  - Then m_ready = 0 and go to REQ.
- REQ:
  - bus_m_req = 1.
  - On bus_m_grant = 1 go to ADDR.
  - No timeout in REQ.
- ADDR: exactly ADDR_WIDTH consecutive cycles.
  - bus_data_out_valid = 1, bus_mode = 0, bus_data_out = addr[i] with i = 0..15; the shift register shifts right each cycle.
  - After the last bit: if write go to WDATA, else go to RDATA.
- WDATA: exactly DATA_WIDTH consecutive cycles.
  - bus_mode = 1, bus_data_out_valid = 1, data LSB first.
  - Then go to WAIT_ACK.
- WAIT_ACK:
  - bus_mode = 1, bus_data_out_valid = 0.
  - On bus_s_ack = 1: pulse m_done and go to IDLE.
- RDATA:
  - bus_mode = 1.
  - Each cycle with bus_data_in_valid, capture bus_data_in into bit position cnt, cnt = 0..7.
  - On the 8th bit: m_rdata is updated and m_rdata_valid and m_done pulse on the next cycle; go to IDLE.
  - bus_data_in_valid is sampled only in RDATA and ignored in all other states.
- bus_mode rules:
  - Held at 1 continuously from the first data-phase cycle until leaving WAIT_ACK/RDATA, with no return to 0 between address and data.
  - 0 in IDLE and REQ.
- bus_m_req:
  - Held 1 from REQ through the end of the transaction.
  - Drops the cycle the port returns to IDLE.
- Timeout:
  - The idle counter runs in WAIT_ACK/RDATA and clears on state entry and on each received bit.
  - On reaching TIMEOUT: pulse m_done and m_err, go to IDLE, discard partial read data (m_rdata unchanged).
- Grant loss: bus_m_grant = 0 in any of ADDR, WDATA, WAIT_ACK or RDATA causes the same abort as timeout (m_done + m_err).
- Simultaneous events:
  - Grant loss and a completing event (bus_s_ack or the 8th read bit) in the same cycle: the completion wins with no error.
  - Timeout expiry and bus_s_ack in the same cycle: the ack wins.
- m_valid while not ready is ignored; only one transaction can be outstanding.
- Back-to-back requests: m_ready = 1 in the cycle after m_done, so the minimum turnaround is 1 IDLE cycle.

Decomposition:
- Shared package bus_pkg holds:
  - enum m_state_t {IDLE, REQ, ADDR, WDATA, WAIT_ACK, RDATA};
  - constants BUS_MODE_ADDR = 0, BUS_MODE_DATA = 1, BUS_RW_WRITE = 1, BUS_RW_READ = 0.
- No sub-module: the shifters and counters stay flat in m_port.

Test Plan:
- Write A=0x1234, D=0xA5, grant after 3 cycles → bus_m_req rises the cycle after acceptance; 16 valid bits LSB-first 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0 with mode = 0; 8 bits 1,0,1,0,0,1,0,1 with mode = 1; ack → m_done = 1, m_err = 0.
- Read A=0x00FF; target returns 8 bits of 0x3C with 2-cycle gaps → m_rdata = 0x3C, single m_rdata_valid + m_done pulse; bus_mode stays 1 through the gaps.
- Write with ack never asserted, TIMEOUT = 64 → m_done + m_err 64 cycles after WAIT_ACK entry; bus_m_req = 0; m_ready = 1 the next cycle.
- Grant dropped at address bit 7 → m_err pulse, bus_data_out_valid = 0 the next cycle, m_rdata unchanged.
- rst asserted mid-WDATA → all outputs at reset values immediately (asynchronous); no m_done pulse; a new request after reset completes normally.
- Read where the 8th bit and grant loss coincide → m_rdata updated, m_err = 0.
